// File: rtl/ibex_rvfi_trace_buffer_pkg.sv
// Shared types and constants for the RVFI trace buffer.
package ibex_rvfi_trace_buffer_pkg;

    typedef enum logic [1:0] {
        TRACE_IDLE   = 2'd0,
        TRACE_ARMED  = 2'd1,
        TRACE_POST   = 2'd2,
        TRACE_FROZEN = 2'd3
    } trace_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] insn;
        logic        trap;
        logic        intr;
        logic [1:0]  mode;
    } trace_entry_t;

    // Bit positions inside rd_flags_o = {trap, intr, mode[1:0]}
    localparam int unsigned FlagTrap   = 3;
    localparam int unsigned FlagIntr   = 2;
    localparam int unsigned FlagModeHi = 1;
    localparam int unsigned FlagModeLo = 0;

    localparam logic [1:0] PrivModeM = 2'b11;

endpackage

// File: rtl/ibex_rvfi_trace_buffer_if.sv
// Readout bus of the trace buffer: oldest entry plus valid/ready pop handshake.
interface ibex_rvfi_trace_buffer_if #(
    parameter int unsigned TsWidth = 32
);
    logic               rd_valid;
    logic               rd_ready;
    logic [31:0]        rd_pc;
    logic [31:0]        rd_insn;
    logic [3:0]         rd_flags;
    logic [TsWidth-1:0] rd_ts;

    modport master (output rd_valid, rd_pc, rd_insn, rd_flags, rd_ts, input rd_ready);
    modport slave  (input rd_valid, rd_pc, rd_insn, rd_flags, rd_ts, output rd_ready);
endinterface

// File: rtl/ibex_rvfi_trace_buffer_ram.sv
// Trace storage: one write port, one asynchronous read port, flop based.
module ibex_rvfi_trace_buffer_ram #(
    parameter int unsigned Depth = 64,
    parameter int unsigned Width = 68
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     we_i,
    input  logic [$clog2(Depth)-1:0] waddr_i,
    input  logic [Width-1:0]         wdata_i,
    input  logic [$clog2(Depth)-1:0] raddr_i,
    output logic [Width-1:0]         rdata_o
);
    logic [Width-1:0] mem_q [Depth];

    // Cleared on reset so a reset discards the trace and the read data idles at zero.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mem_q <= '{default: '0};
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/ibex_rvfi_trace_buffer.sv
// RVFI retirement trace buffer: circular capture, wrap or stop-when-full, PC/interrupt trigger.
// Optional per-entry cycle timestamp enabled by defining IBEX_TRACE_TIMESTAMP_EN.
module ibex_rvfi_trace_buffer
    import ibex_rvfi_trace_buffer_pkg::*;
#(
    parameter int unsigned Depth        = 64,
    parameter int unsigned PostCntWidth = 16,
    parameter int unsigned TsWidth      = 32,
    parameter logic [1:0]  ModeMask     = 2'b11
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     rvfi_valid_i,
    input  logic [31:0]              rvfi_pc_rdata_i,
    input  logic [31:0]              rvfi_insn_i,
    input  logic                     rvfi_trap_i,
    input  logic                     rvfi_intr_i,
    input  logic [1:0]               rvfi_mode_i,
    input  logic                     cfg_arm_i,
    input  logic                     cfg_stop_i,
    input  logic                     cfg_wrap_i,
    input  logic                     trig_pc_en_i,
    input  logic [31:0]              trig_pc_i,
    input  logic                     trig_intr_en_i,
    input  logic [PostCntWidth-1:0]  post_cnt_i,
    ibex_rvfi_trace_buffer_if.master rd,
    output logic [$clog2(Depth):0]   count_o,
    output logic [1:0]               state_o,
    output logic                     triggered_o,
    output logic                     overflow_o
);
    localparam int unsigned AW     = $clog2(Depth);
    localparam int unsigned EntryW = $bits(trace_entry_t);
    localparam logic [AW:0] CntFull = (AW+1)'(Depth);
    localparam logic [AW:0] CntLast = (AW+1)'(Depth - 1);

    trace_state_e            state_q, state_d;
    logic [AW-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]             count_q, count_d;
    logic [PostCntWidth-1:0] post_q, post_d;
    logic                    trig_q, trig_d, ovf_q, ovf_d;
    logic                    capture, hit, pop;
    trace_entry_t            wentry, rentry;

`ifdef IBEX_TRACE_TIMESTAMP_EN
    localparam int unsigned RamW = EntryW + TsWidth;
    logic [TsWidth-1:0] ts_q, ts_d;
    logic [RamW-1:0]    wdata, rdata;

    assign ts_d = ts_q + TsWidth'(1);
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) ts_q <= '0;
        else       ts_q <= ts_d;
    end
    assign wdata    = {ts_q, wentry};
    assign rd.rd_ts = rdata[EntryW +: TsWidth];
`else
    localparam int unsigned RamW = EntryW;
    logic [RamW-1:0] wdata, rdata;

    assign wdata    = wentry;
    assign rd.rd_ts = '0;
`endif

    // Arm has priority: a retirement in the arming cycle is dropped with the old trace.
    assign capture = rvfi_valid_i && !cfg_arm_i && ModeMask[rvfi_mode_i == PrivModeM] &&
                     (state_q inside {TRACE_ARMED, TRACE_POST});
    assign hit     = capture && (state_q == TRACE_ARMED) &&
                     ((trig_pc_en_i && (rvfi_pc_rdata_i == trig_pc_i)) ||
                      (trig_intr_en_i && rvfi_intr_i));
    assign pop     = rd.rd_valid && rd.rd_ready;

    assign wentry = '{pc: rvfi_pc_rdata_i, insn: rvfi_insn_i, trap: rvfi_trap_i,
                      intr: rvfi_intr_i, mode: rvfi_mode_i};

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        post_d   = post_q;
        trig_d   = trig_q;
        ovf_d    = ovf_q;
        if (cfg_arm_i) begin
            state_d  = TRACE_ARMED;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            post_d   = '0;
            trig_d   = 1'b0;
            ovf_d    = 1'b0;
        end else begin
            if (capture) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
                if (count_q == CntFull) begin
                    rd_ptr_d = rd_ptr_q + AW'(1);
                    ovf_d    = 1'b1;
                end else begin
                    count_d = count_q + (AW+1)'(1);
                end
                if (hit) begin
                    trig_d  = 1'b1;
                    post_d  = post_cnt_i;
                    state_d = (post_cnt_i == '0) ? TRACE_FROZEN : TRACE_POST;
                end else if (state_q == TRACE_POST) begin
                    post_d = post_q - PostCntWidth'(1);
                    if (post_q == PostCntWidth'(1)) state_d = TRACE_FROZEN;
                end
                // Stop-when-full: this store fills the buffer, so freeze now.
                if (!cfg_wrap_i && count_q >= CntLast) begin
                    state_d = TRACE_FROZEN;
                    if (state_q == TRACE_POST) ovf_d = 1'b1;
                end
            end
            if (cfg_stop_i && state_q != TRACE_IDLE) state_d = TRACE_FROZEN;
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
                count_d  = count_q - (AW+1)'(1);
                if (count_q == (AW+1)'(1)) state_d = TRACE_IDLE;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= TRACE_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            post_q   <= '0;
            trig_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            post_q   <= post_d;
            trig_q   <= trig_d;
            ovf_q    <= ovf_d;
        end
    end

    ibex_rvfi_trace_buffer_ram #(.Depth(Depth), .Width(RamW)) u_ram (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .we_i    (capture),
        .waddr_i (wr_ptr_q),
        .wdata_i (wdata),
        .raddr_i (rd_ptr_q),
        .rdata_o (rdata)
    );

    assign rentry = trace_entry_t'(rdata[EntryW-1:0]);

    always_comb begin
        rd.rd_flags                        = '0;
        rd.rd_flags[FlagTrap]              = rentry.trap;
        rd.rd_flags[FlagIntr]              = rentry.intr;
        rd.rd_flags[FlagModeHi:FlagModeLo] = rentry.mode;
    end

    assign rd.rd_valid  = (state_q inside {TRACE_FROZEN, TRACE_IDLE}) && (count_q != '0);
    assign rd.rd_pc     = rentry.pc;
    assign rd.rd_insn   = rentry.insn;
    assign count_o      = count_q;
    assign state_o      = state_q;
    assign triggered_o  = trig_q;
    assign overflow_o   = ovf_q;
endmodule

// File: tb/tb_ibex_rvfi_trace_buffer.sv
// Bench for ibex_rvfi_trace_buffer: queue-based reference model checked every cycle plus directed literals.
module tb_ibex_rvfi_trace_buffer;
    localparam int DEPTH = 64;
    localparam logic [1:0] MASK = 2'b11;

    logic clk = 1'b0, rst = 1'b1;
    logic valid = 0, trap = 0, intr = 0;
    logic [31:0] pc = 0, insn = 0, tpc = 0;
    logic [1:0] mode = 0;
    logic arm = 0, stop = 0, wrap = 0, tpc_en = 0, tintr_en = 0, rd_ready = 0;
    logic [15:0] post = 0;
    logic [6:0] count, count_m;
    logic [1:0] state, state_m;
    logic trig, trig_m, ovf, ovf_m;
    int nchk = 0, nerr = 0;

    ibex_rvfi_trace_buffer_if #(.TsWidth(32)) rif();
    ibex_rvfi_trace_buffer_if #(.TsWidth(32)) rif_m();
    assign rif.rd_ready   = rd_ready;
    assign rif_m.rd_ready = rd_ready;

    always #5 clk = ~clk;

    ibex_rvfi_trace_buffer dut (
        .clk_i(clk), .rst_i(rst), .rvfi_valid_i(valid), .rvfi_pc_rdata_i(pc), .rvfi_insn_i(insn),
        .rvfi_trap_i(trap), .rvfi_intr_i(intr), .rvfi_mode_i(mode), .cfg_arm_i(arm), .cfg_stop_i(stop),
        .cfg_wrap_i(wrap), .trig_pc_en_i(tpc_en), .trig_pc_i(tpc), .trig_intr_en_i(tintr_en),
        .post_cnt_i(post), .rd(rif), .count_o(count), .state_o(state), .triggered_o(trig),
        .overflow_o(ovf));

    ibex_rvfi_trace_buffer #(.ModeMask(2'b10)) dut_m (
        .clk_i(clk), .rst_i(rst), .rvfi_valid_i(valid), .rvfi_pc_rdata_i(pc), .rvfi_insn_i(insn),
        .rvfi_trap_i(trap), .rvfi_intr_i(intr), .rvfi_mode_i(mode), .cfg_arm_i(arm), .cfg_stop_i(stop),
        .cfg_wrap_i(wrap), .trig_pc_en_i(tpc_en), .trig_pc_i(tpc), .trig_intr_en_i(tintr_en),
        .post_cnt_i(post), .rd(rif_m), .count_o(count_m), .state_o(state_m), .triggered_o(trig_m),
        .overflow_o(ovf_m));

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: the trace is a queue, oldest entry at the front.
    typedef struct {
        logic [31:0] pc;
        logic [31:0] insn;
        logic [3:0]  flags;
        logic [31:0] ts;
    } m_ent_t;
    m_ent_t mq[$];
    int m_state = 0, m_post = 0, ns;
    bit m_trig = 0, m_ovf = 0, cap, hit, mpop;
    logic [31:0] m_ts = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            m_state = 0; m_trig = 0; m_ovf = 0; m_post = 0; m_ts = 0;
        end else begin
            mpop = (m_state == 0 || m_state == 3) && mq.size() != 0 && rd_ready;
            cap  = !arm && valid && (m_state == 1 || m_state == 2) && MASK[mode == 2'b11];
            hit  = cap && m_state == 1 && ((tpc_en && pc == tpc) || (tintr_en && intr));
            if (arm) begin
                mq.delete();
                m_state = 1; m_trig = 0; m_ovf = 0;
            end else begin
                ns = m_state;
                if (cap) begin
                    if (mq.size() == DEPTH) begin
                        void'(mq.pop_front());
                        m_ovf = 1;
                    end
                    mq.push_back('{pc: pc, insn: insn, flags: {trap, intr, mode}, ts: m_ts});
                    if (hit) begin
                        m_trig = 1; m_post = int'(post);
                        ns = (post == 0) ? 3 : 2;
                    end else if (m_state == 2) begin
                        m_post--;
                        if (m_post == 0) ns = 3;
                    end
                    if (!wrap && mq.size() == DEPTH) begin
                        ns = 3;
                        if (m_state == 2) m_ovf = 1;
                    end
                end
                if (stop && m_state != 0) ns = 3;
                if (mpop) begin
                    void'(mq.pop_front());
                    if (mq.size() == 0) ns = 0;
                end
                m_state = ns;
            end
            m_ts = m_ts + 1;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("state", state, m_state);
            chk("count", count, mq.size());
            chk("rd_valid", rif.rd_valid, (m_state == 0 || m_state == 3) && mq.size() != 0);
            chk("triggered", trig, m_trig);
            chk("overflow", ovf, m_ovf);
            if ((m_state == 0 || m_state == 3) && mq.size() != 0) begin
                chk("rd_pc", rif.rd_pc, mq[0].pc);
                chk("rd_insn", rif.rd_insn, mq[0].insn);
                chk("rd_flags", rif.rd_flags, mq[0].flags);
`ifdef IBEX_TRACE_TIMESTAMP_EN
                chk("rd_ts", rif.rd_ts, mq[0].ts);
`else
                chk("rd_ts", rif.rd_ts, 0);
`endif
            end
        end
    end

    task automatic retire(input logic [31:0] p, input logic i_intr, input logic [1:0] m);
        valid = 1; pc = p; insn = ~p; trap = 0; intr = i_intr; mode = m;
        @(posedge clk); #1;
        valid = 0; intr = 0;
    endtask

    task automatic pulse_arm();
        arm = 1; @(posedge clk); #1; arm = 0;
    endtask

    task automatic pulse_stop();
        stop = 1; @(posedge clk); #1; stop = 0;
    endtask

    task automatic drain(input bit rnd);
        for (int k = 0; k < 2000 && count != 0; k++) begin
            rd_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(posedge clk); #1;
        end
        rd_ready = 0;
        chk("drain_empty", count, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_state", state, 0);
        chk("rst_count", count, 0);
        chk("rst_valid", rif.rd_valid, 0);
        chk("rst_trig", trig, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_pc", rif.rd_pc, 0);
        chk("rst_insn", rif.rd_insn, 0);
        chk("rst_flags", rif.rd_flags, 0);
        chk("rst_ts", rif.rd_ts, 0);
        @(posedge clk); #1 rst = 0;

        // Stop-when-full
        wrap = 0;
        pulse_arm();
        for (int i = 0; i < 70; i++) begin
            retire(32'h100 + 4 * i, 1'b0, 2'b11);
            if (i == 62) chk("s1_armed_63", state, 1);
            if (i == 63) chk("s1_frozen_64", state, 3);
        end
        @(negedge clk);
        chk("s1_count", count, 64);
        chk("s1_ovf", ovf, 0);
        rd_ready = 1;
        for (int i = 0; i < 64; i++) begin
            chk("s1_pop_pc", rif.rd_pc, 32'h100 + 4 * i);
            @(negedge clk);
        end
        rd_ready = 0;
        chk("s1_idle", state, 0);
        chk("s1_valid", rif.rd_valid, 0);

        // Wrap mode
        wrap = 1;
        pulse_arm();
        for (int i = 0; i < 70; i++) retire(32'h100 + 4 * i, 1'b0, 2'b11);
        @(negedge clk);
        chk("s2_armed", state, 1);
        pulse_stop();
        @(negedge clk);
        chk("s2_frozen", state, 3);
        chk("s2_count", count, 64);
        chk("s2_ovf", ovf, 1);
        chk("s2_first_pc", rif.rd_pc, 32'h118);
        drain(0);

        // PC trigger with post count
        wrap = 0; tpc_en = 1; tpc = 32'h140; post = 3;
        pulse_arm();
        for (int i = 0; i < 30; i++) begin
            retire(32'h100 + 4 * i, 1'b0, 2'b11);
            if (i == 15) chk("s3_not_trig", trig, 0);
            if (i == 16) begin
                chk("s3_trig", trig, 1);
                chk("s3_post", state, 2);
            end
        end
        @(negedge clk);
        chk("s3_frozen", state, 3);
        chk("s3_count", count, 20);
        drain(0);
        tpc_en = 0;

        // Interrupt trigger, post count 0
        tintr_en = 1; post = 0;
        pulse_arm();
        for (int i = 0; i < 5; i++) retire(32'h200 + 4 * i, i == 4, 2'b11);
        @(negedge clk);
        chk("s4_frozen", state, 3);
        chk("s4_count", count, 5);
        rd_ready = 1;
        repeat (4) @(negedge clk);
        rd_ready = 0;
        chk("s4_last_pc", rif.rd_pc, 32'h210);
        chk("s4_last_flags", rif.rd_flags, 4'b0111);
        drain(0);
        tintr_en = 0;

        // Mode mask: only M-mode captured on dut_m
        pulse_arm();
        for (int i = 0; i < 10; i++) retire(32'h300 + 4 * i, 1'b0, (i % 2 != 0) ? 2'b11 : 2'b00);
        @(negedge clk);
        chk("s5_count_m", count_m, 5);
        chk("s5_count", count, 10);
        pulse_stop();
        @(negedge clk);
        chk("s5_frozen_m", state_m, 3);
        rd_ready = 1;
        for (int i = 0; i < 5; i++) begin
            chk("s5_mode_m", rif_m.rd_flags[1:0], 2'b11);
            chk("s5_pc_m", rif_m.rd_pc, 32'h304 + 8 * i);
            @(negedge clk);
        end
        rd_ready = 0;
        chk("s5_empty_m", count_m, 0);
        chk("s5_idle_m", state_m, 0);
        drain(0);

        // Reset mid-capture
        wrap = 1;
        pulse_arm();
        for (int i = 0; i < 30; i++) retire(32'h400 + 4 * i, 1'b0, 2'b11);
        @(negedge clk);
        chk("s6_count", count, 30);
        chk("s6_armed", state, 1);
        #2 rst = 1;
        @(negedge clk);
        chk("s6_rst_count", count, 0);
        chk("s6_rst_state", state, 0);
        chk("s6_rst_valid", rif.rd_valid, 0);
        chk("s6_rst_trig", trig, 0);
        chk("s6_rst_ovf", ovf, 0);
        @(posedge clk); #1 rst = 0;

        // Randomized rounds against the model
        for (int r = 0; r < 6; r++) begin
            wrap = r[0];
            tpc_en = 1'($urandom_range(0, 1));
            tpc = 32'h100 + 4 * $urandom_range(0, 40);
            tintr_en = 1'($urandom_range(0, 1));
            post = 16'($urandom_range(0, 12));
            pulse_arm();
            repeat (200) begin
                valid = $urandom_range(0, 3) != 0;
                pc = 32'h100 + 4 * $urandom_range(0, 63);
                insn = $urandom;
                trap = 1'($urandom_range(0, 1));
                intr = $urandom_range(0, 7) == 0;
                mode = $urandom_range(0, 1) != 0 ? 2'b11 : 2'b00;
                rd_ready = 1'($urandom_range(0, 1));
                stop = $urandom_range(0, 99) == 0;
                @(posedge clk); #1;
            end
            valid = 0; intr = 0; stop = 0;
            pulse_stop();
            drain(1);
        end

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
